conv3x3_mac: RTL

//   Downstream of the line buffer. Takes one 3-pixel column (l1/l2/l3 taps) per shift_buffer pulse and

---
 rtl/npu_pkg.sv | 21 ++
 rtl/mac9_tree.sv | 60 ++++++
 rtl/conv3x3_mac.sv | 112 +++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared constants, state type and emit-rule helpers for the 3x3 convolution MAC.
package npu_pkg;
  localparam int BIT_DEPTH   = 8;
  localparam int COLS        = 28;
  localparam int ACC_W       = 2*BIT_DEPTH+4;
  localparam int KERNEL_TAPS = 9;
  localparam int PROD_W      = 2*BIT_DEPTH+1;
  localparam int CNT_W       = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} conv_state_t;

  // Stride 2 only issues window positions with an even left column.
  function automatic logic issue_ok(logic [CNT_W-1:0] p, logic stride2);
    return !stride2 || !p[0];
  endfunction

  // An issue is the row's last when the next position would run off the row.
  function automatic logic is_last(logic [CNT_W-1:0] p, logic stride2);
    return (int'(p) + (stride2 ? 2 : 1)) > (COLS-3);
  endfunction
endpackage

// File: rtl/mac9_tree.sv
// Two-stage 3x3 MAC: registered signed products, then registered sum; valid/last ride along.
module mac9_tree
  import npu_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] win,
  input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] wgt,
  output logic                           s1_valid,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [ACC_W-1:0]               acc_out
);
  localparam int STAGES = 2;

  logic [STAGES:1]          vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]          last_pipe_q, last_pipe_d;
  logic signed [PROD_W-1:0] prod_q [KERNEL_TAPS];
  logic signed [PROD_W-1:0] prod_d [KERNEL_TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  always_comb begin
    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], in_valid};
    last_pipe_d = {last_pipe_q[STAGES-1:1], in_last};
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      prod_d[k] = prod_q[k];
      // Pixels are unsigned: a zero MSB keeps them positive in the signed multiply.
      if (in_valid)
        prod_d[k] = $signed({1'b0, win[k*BIT_DEPTH +: BIT_DEPTH]}) *
                    $signed(wgt[k*BIT_DEPTH +: BIT_DEPTH]);
    end
    acc_d = acc_q;
    if (vld_pipe_q[1]) begin
      acc_d = '0;
      for (int k = 0; k < KERNEL_TAPS; k++)
        acc_d = acc_d + {{(ACC_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      acc_q       <= '0;
      for (int k = 0; k < KERNEL_TAPS; k++) prod_q[k] <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      acc_q       <= acc_d;
      for (int k = 0; k < KERNEL_TAPS; k++) prod_q[k] <= prod_d[k];
    end
  end

  assign s1_valid  = vld_pipe_q[1];
  assign out_valid = vld_pipe_q[STAGES];
  assign out_last  = last_pipe_q[STAGES];
  assign acc_out   = acc_q;
endmodule

// File: rtl/conv3x3_mac.sv
// Sliding 3x3 window over a streamed row of pixel columns, convolved with a writable signed kernel.
module conv3x3_mac
  import npu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           stride,
  input  logic                 shift_in,
  input  logic [BIT_DEPTH-1:0] px_l1,
  input  logic [BIT_DEPTH-1:0] px_l2,
  input  logic [BIT_DEPTH-1:0] px_l3,
  input  logic                 wr_en,
  input  logic [3:0]           w_addr,
  input  logic [BIT_DEPTH-1:0] w_data,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 row_done
);
  conv_state_t                               state_q, state_d;
  logic                                      stride2_q, stride2_d;
  logic [CNT_W-1:0]                          col_cnt_q, col_cnt_d;
  logic [KERNEL_TAPS-1:0][BIT_DEPTH-1:0]     win_q, win_d;
  logic [KERNEL_TAPS-1:0][BIT_DEPTH-1:0]     wgt_q, wgt_d;
  logic                                      issue_q, issue_d;
  logic                                      last_q, last_d;
  logic [2:0][BIT_DEPTH-1:0]                 px;
  logic [CNT_W-1:0]                          p;
  logic                                      s1_valid, out_last;

  assign px = {px_l3, px_l2, px_l1};
  assign p  = col_cnt_q - CNT_W'(2);

  always_comb begin
    state_d   = state_q;
    stride2_d = stride2_q;
    col_cnt_d = col_cnt_q;
    win_d     = win_q;
    wgt_d     = wgt_q;
    issue_d   = 1'b0;
    last_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A write together with start still lands, so the new kernel is used by this row.
        if (wr_en)
          for (int k = 0; k < KERNEL_TAPS; k++)
            if (w_addr == 4'(k)) wgt_d[k] = w_data;
        if (start) begin
          state_d   = FILL;
          stride2_d = (stride == 2'd2);
          col_cnt_d = '0;
          win_d     = '0;
        end
      end
      FILL, RUN: begin
        if (shift_in) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r*3+0] = win_q[r*3+1];
            win_d[r*3+1] = win_q[r*3+2];
            win_d[r*3+2] = px[r];
          end
          col_cnt_d = col_cnt_q + 1'b1;
          if (col_cnt_q >= CNT_W'(2) && issue_ok(p, stride2_q)) begin
            issue_d = 1'b1;
            last_d  = is_last(p, stride2_q);
          end
          if (state_q == FILL && col_cnt_q == CNT_W'(1))      state_d = RUN;
          if (state_q == RUN  && col_cnt_q == CNT_W'(COLS-1)) state_d = DRAIN;
        end
      end
      DRAIN: if (!issue_q && !s1_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stride2_q <= 1'b0;
      col_cnt_q <= '0;
      win_q     <= '0;
      wgt_q     <= '0;
      issue_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stride2_q <= stride2_d;
      col_cnt_q <= col_cnt_d;
      win_q     <= win_d;
      wgt_q     <= wgt_d;
      issue_q   <= issue_d;
      last_q    <= last_d;
    end
  end

  mac9_tree u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_q),
    .in_last   (last_q),
    .win       (win_q),
    .wgt       (wgt_q),
    .s1_valid  (s1_valid),
    .out_valid (out_valid),
    .out_last  (out_last),
    .acc_out   (acc_out)
  );

  assign busy     = (state_q != IDLE);
  assign row_done = out_valid & out_last;
endmodule
